pll_lock_sequencer: RTL and testbench

//  Power-up/recovery sequencer for the multi-output system PLL (50 MHz ref -> 28/14/7/56/112 MHz).

---
 rtl/pll_lock_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Power-up and recovery sequencer for the multi-output system PLL. Runs on the PLL
//   reference clock. It pulses the PLL reset, waits for a filtered lock, and retries on
//   timeout. It holds the core system reset until the clocks are stable, then releases it.
//   The sequence re-runs on loss of lock or on a software restart request.
//
// Ports
//   refclk_i        reference clock (sole clock)
//   rst_i           asynchronous active-high reset
//   pll_locked_i    PLL lock indication, asynchronous; synchronised by two flops
//   restart_i       single-cycle synchronous request to re-initialise the PLL
//   pll_rst_o       reset to the PLL
//   sys_rst_o       core system reset, active-high
//   ready_o         high only in RUN, with sys_rst_o low
//   lock_lost_o     one-cycle pulse when synced lock drops in HOLD or RUN
//   retry_count_o   number of lock timeouts, saturating at 255
//   state_o         FSM state encoding, for debug
//
// All outputs are registered. The output flops load values decoded from the next state,
// so they always agree with state_o.

module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES   = 32,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned SYS_RST_HOLD       = 64,
  parameter int unsigned CNT_W              = 17
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [7:0] retry_count_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StHold     = 3'd3,
    StRun      = 3'd4
  } state_e;

  // Terminal counts. The shared counter is cleared on every state change, so each
  // state spends exactly "last + 1" cycles before its expiry transition.
  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(SYS_RST_HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             sync1_q, sync2_q;
  logic             lk;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge refclk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked_i;
      sync2_q <= sync1_q;
    end
  end

  assign lk = sync2_q;

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    case (state_q)
      StPllRst: begin
        // restart is deliberately ignored: the PLL is already being reset.
        if (cnt_q == RstLast) state_d = StWaitLock;
      end

      StWaitLock: begin
        if (restart_i) begin
          state_d = StPllRst;
        end else if (lk) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StPllRst;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end
      end

      StStable: begin
        // A lock drop outranks restart; falling back to WAITLOCK restarts the timeout.
        if (!lk) begin
          state_d = StWaitLock;
        end else if (restart_i) begin
          state_d = StPllRst;
        end else if (cnt_q == StableLast) begin
          state_d = StHold;
        end
      end

      StHold: begin
        if (!lk) begin
          state_d     = StPllRst;
          lock_lost_d = 1'b1;
        end else if (restart_i) begin
          state_d = StPllRst;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
        end
      end

      StRun: begin
        // No expiry in RUN; hold the counter still instead of letting it wrap.
        cnt_d = cnt_q;
        if (!lk) begin
          state_d     = StPllRst;
          lock_lost_d = 1'b1;
        end else if (restart_i) begin
          state_d = StPllRst;
        end
      end

      default: begin
        // Unused encodings recover through a full PLL reset.
        state_d = StPllRst;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so the registered copies switch on the
  // same edge as the state itself; this keeps ready and sys_rst mutually consistent.
  always_comb begin
    pll_rst_d = (state_d == StPllRst);
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
  end

  always_ff @(posedge refclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      retry_q     <= 8'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst_o     = pll_rst_q;
  assign sys_rst_o     = sys_rst_q;
  assign ready_o       = ready_q;
  assign lock_lost_o   = lock_lost_q;
  assign retry_count_o = retry_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed testbench for pll_lock_sequencer, using reduced cycle parameters so that the
// timeout and saturation paths fit in a short run. All inputs are driven and all outputs
// are sampled on the falling clock edge.

module tb_pll_lock_sequencer;

  localparam int unsigned N  = 4;   // PLL reset pulse
  localparam int unsigned LS = 8;   // lock stable cycles
  localparam int unsigned T  = 24;  // lock timeout
  localparam int unsigned H  = 6;   // sys_rst hold
  localparam int unsigned K  = 2 + LS + H + 1;  // pll_locked rise -> sys_rst fall

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int entries  = 0;
  int pulses   = 0;
  bit saw_hold = 1'b0;
  logic [2:0] prev_state = 3'd0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES  (N),
    .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT      (T),
    .SYS_RST_HOLD      (H),
    .CNT_W             (8)
  ) u_dut (
    .refclk_i     (clk),
    .rst_i        (rst),
    .pll_locked_i (pll_locked),
    .restart_i    (restart),
    .pll_rst_o    (pll_rst),
    .sys_rst_o    (sys_rst),
    .ready_o      (ready),
    .lock_lost_o  (lock_lost),
    .retry_count_o(retry_count),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int guard = 0;
    while (state !== s && guard < 200) begin
      tick();
      guard++;
    end
    check_eq(tag, state, s);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pll_rst"}, pll_rst, 1);
    check_eq({tag, "_sys_rst"}, sys_rst, 1);
    check_eq({tag, "_ready"}, ready, 0);
    check_eq({tag, "_lock_lost"}, lock_lost, 0);
    check_eq({tag, "_retry"}, retry_count, 0);
    check_eq({tag, "_state"}, state, 0);
  endtask

  // Event counters and the ready/sys_rst/state consistency check.
  always @(negedge clk) begin
    if (state == 3'd0 && prev_state != 3'd0) entries++;
    if (lock_lost) pulses++;
    if (state == 3'd3) saw_hold = 1'b1;
    prev_state = state;
    check_eq("ready_consistent", ready, (state == 3'd4) && !sys_rst);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int hi;
    rst        = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");

    // Timeout path: lock never arrives.
    rst = 1'b0;
    repeat (N - 1) tick();
    check_eq("to_pll_rst_hi", pll_rst, 1);
    tick();
    check_eq("to_pll_rst_lo", pll_rst, 0);
    check_eq("to_waitlock", state, 1);
    repeat (T - 1) tick();
    check_eq("to_retry0", retry_count, 0);
    tick();
    check_eq("to_retry1", retry_count, 1);
    check_eq("to_back_pllrst", state, 0);
    check_eq("to_pll_rst_again", pll_rst, 1);
    repeat (N + T) tick();
    check_eq("to_retry2", retry_count, 2);
    repeat (N + T) tick();
    check_eq("to_retry3", retry_count, 3);
    guard = 0;
    while (retry_count !== 8'd255 && guard < 300 * (N + T)) begin
      tick();
      guard++;
    end
    check_eq("retry_reach_sat", retry_count, 255);
    repeat (3 * (N + T)) tick();
    check_eq("retry_sat_hold", retry_count, 255);

    // Clean lock.
    rst = 1'b1;
    tick();
    check_eq("retry_cleared", retry_count, 0);
    rst = 1'b0;
    hi  = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_rst) hi++;
      tick();
    end
    check_eq("clean_pll_rst_len", hi, N);
    check_eq("clean_waitlock", state, 1);
    pll_locked = 1'b1;
    repeat (K - 1) tick();
    check_eq("clean_sys_rst_held", sys_rst, 1);
    check_eq("clean_in_hold", state, 3);
    check_eq("clean_not_ready", ready, 0);
    tick();
    check_eq("clean_sys_rst_rel", sys_rst, 0);
    check_eq("clean_ready", ready, 1);
    check_eq("clean_run", state, 4);
    check_eq("clean_retry", retry_count, 0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    repeat (2) tick();
    check_eq("ll_no_pulse_yet", lock_lost, 0);
    check_eq("ll_still_ready", ready, 1);
    tick();
    check_eq("ll_pulse", lock_lost, 1);
    check_eq("ll_sys_rst", sys_rst, 1);
    check_eq("ll_ready", ready, 0);
    check_eq("ll_pll_rst", pll_rst, 1);
    tick();
    check_eq("ll_pulse_end", lock_lost, 0);
    repeat (N - 2) tick();
    check_eq("ll_pll_rst_hi", pll_rst, 1);
    tick();
    check_eq("ll_pll_rst_lo", pll_rst, 0);
    check_eq("ll_waitlock", state, 1);
    pll_locked = 1'b1;
    repeat (K) tick();
    check_eq("ll_relock_ready", ready, 1);

    // Restart in RUN.
    entries = 0;
    pulses  = 0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("rs_state", state, 0);
    check_eq("rs_pll_rst", pll_rst, 1);
    check_eq("rs_no_pulse", lock_lost, 0);
    wait_state(3'd4, "rs_back_run");
    check_eq("rs_entries", entries, 1);
    check_eq("rs_pulses", pulses, 0);

    // Restart coincident with a lock drop.
    entries    = 0;
    pulses     = 0;
    pll_locked = 1'b0;
    repeat (2) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("co_pulse", lock_lost, 1);
    check_eq("co_state", state, 0);
    tick();
    check_eq("co_pulse_end", lock_lost, 0);
    pll_locked = 1'b1;
    wait_state(3'd4, "co_back_run");
    check_eq("co_entries", entries, 1);
    check_eq("co_pulses", pulses, 1);

    // Glitchy lock.
    pll_locked = 1'b0;
    wait_state(3'd1, "gl_waitlock");
    saw_hold   = 1'b0;
    pll_locked = 1'b1;
    repeat (5) tick();
    check_eq("gl_stable", state, 2);
    pll_locked = 1'b0;
    repeat (2) tick();
    check_eq("gl_still_stable", state, 2);
    tick();
    check_eq("gl_back_waitlock", state, 1);
    check_eq("gl_no_hold", saw_hold, 0);
    pll_locked = 1'b1;
    repeat (K - 1) tick();
    check_eq("gl_sys_rst_held", sys_rst, 1);
    tick();
    check_eq("gl_sys_rst_rel", sys_rst, 0);

    // Asynchronous reset while in HOLD.
    pll_locked = 1'b0;
    wait_state(3'd1, "ar_waitlock");
    pll_locked = 1'b1;
    wait_state(3'd3, "ar_hold");
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    tick();
    rst = 1'b0;
    repeat (N + 1 + LS + H - 1) tick();
    check_eq("ar_sys_rst_held", sys_rst, 1);
    tick();
    check_eq("ar_sys_rst_rel", sys_rst, 0);
    check_eq("ar_ready", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
